goomba_spawn_scheduler: RTL and testbench



---
 rtl/mario_pkg.sv | 23 ++
 rtl/lowest_free_slot.sv | 24 ++
 rtl/goomba_spawn_scheduler.sv | 133 +++++++++++++
 tb/tb_goomba_spawn_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared types and constants for the enemy spawn logic.
// Spawn-entry layout, default spawn constants and scheduler FSM states.
package mario_pkg;

  typedef struct packed {
    logic [7:0] col;
    logic [9:0] y;
  } spawn_entry_t;

  localparam logic [7:0] END_COL_DEF = 8'hFF;
  localparam logic [9:0] SPAWN_X_DEF = 10'd500;
  localparam int unsigned COL_PX     = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CHECK,
    S_ISSUE,
    S_DONE
  } spawn_state_e;

endpackage

// File: rtl/lowest_free_slot.sv
// Priority encoder: lowest set bit of the free-slot mask.
// Ports: free (mask in), found (any set), idx (lowest set index).
module lowest_free_slot #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  free,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan high to low so the last hit is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/goomba_spawn_scheduler.sv
// Walks the column-sorted spawn ROM and starts goomba slots as they scroll in.
// Ports: Clk/Reset_n, frame_clk, Shift, restart, isAlive, ROM bus, start/kill, spawn bus, status.
module goomba_spawn_scheduler
  import mario_pkg::*;
#(
  parameter int          NUM_GOOMBA = 4,
  parameter int          TABLE_AW   = 6,
  parameter int          VIEW_COLS  = 12,
  parameter logic [9:0]  SPAWN_X    = SPAWN_X_DEF,
  parameter logic [7:0]  END_COL    = END_COL_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  frame_clk,
  input  logic                  Shift,
  input  logic                  restart,
  input  logic [NUM_GOOMBA-1:0] isAlive,
  output logic [TABLE_AW-1:0]   table_addr,
  input  logic [17:0]           table_data,
  output logic [NUM_GOOMBA-1:0] start,
  output logic [NUM_GOOMBA-1:0] kill,
  output logic [9:0]            spawnX,
  output logic [9:0]            spawnY,
  output logic [7:0]            scroll_col,
  output logic                  table_done
);

  localparam int IW = (NUM_GOOMBA > 1) ? $clog2(NUM_GOOMBA) : 1;

  spawn_state_e state, state_nx;

  logic                  frame_q;
  logic                  frame_edge;
  logic [TABLE_AW-1:0]   ptr;
  logic [NUM_GOOMBA-1:0] pending;
  logic [NUM_GOOMBA-1:0] free_slots;
  spawn_entry_t          entry;
  logic                  slot_found;
  logic [IW-1:0]         slot_idx;
  logic [8:0]            view_lim;
  logic                  in_view;

  assign free_slots = ~isAlive & ~pending;

  lowest_free_slot #(
    .N  (NUM_GOOMBA),
    .IW (IW)
  ) u_slot (
    .free  (free_slots),
    .found (slot_found),
    .idx   (slot_idx)
  );

  // 9-bit sum so a view window past column 255 does not wrap.
  assign view_lim   = {1'b0, scroll_col} + 9'(VIEW_COLS);
  assign in_view    = {1'b0, entry.col} <= view_lim;
  assign table_addr = ptr;
  assign table_done = (state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (frame_edge) state_nx = S_FETCH;
      S_FETCH: state_nx = S_WAIT;
      S_WAIT:  state_nx = S_CHECK;
      S_CHECK: begin
        if (entry.col == END_COL)
          state_nx = S_DONE;
        else if (in_view && slot_found)
          state_nx = S_ISSUE;
        else
          state_nx = S_IDLE;
      end
      S_ISSUE: state_nx = (&ptr) ? S_DONE : S_IDLE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (restart) state_nx = S_IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      // Reset high so a frame_clk already high at release is not an edge.
      frame_q    <= 1'b1;
      frame_edge <= 1'b0;
      ptr        <= '0;
      pending    <= '0;
      scroll_col <= '0;
      entry      <= '0;
      start      <= '0;
      kill       <= '0;
      spawnX     <= '0;
      spawnY     <= '0;
    end else begin
      state      <= state_nx;
      frame_q    <= frame_clk;
      frame_edge <= frame_clk & ~frame_q & ~restart;
      kill       <= {NUM_GOOMBA{restart}};
      start      <= '0;
      spawnX     <= '0;
      spawnY     <= '0;
      pending    <= pending & ~isAlive & ~kill;

      if (Shift && scroll_col != 8'hFE)
        scroll_col <= scroll_col + 8'd1;

      if (state == S_WAIT)
        entry <= table_data;

      if (state == S_CHECK && state_nx == S_ISSUE) begin
        start  <= NUM_GOOMBA'(1) << slot_idx;
        spawnX <= SPAWN_X;
        spawnY <= entry.y;
      end

      if (state == S_ISSUE) begin
        pending <= (pending & ~isAlive & ~kill) | start;
        ptr     <= ptr + TABLE_AW'(1);
      end

      if (restart) begin
        ptr        <= '0;
        scroll_col <= '0;
        pending    <= '0;
        start      <= '0;
        spawnX     <= '0;
        spawnY     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_goomba_spawn_scheduler.sv
// Self-checking bench for goomba_spawn_scheduler.
// Vector table, directed corner sequences and randomized frames vs a model.
module tb_goomba_spawn_scheduler;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       Shift = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] isAlive = 4'b0;
  logic [5:0] table_addr;
  logic [17:0] table_data;
  logic [3:0] start, kill;
  logic [9:0] spawnX, spawnY;
  logic [7:0] scroll_col;
  logic       table_done;

  logic [17:0] rom [64];

  int total = 0;
  int bad = 0;

  goomba_spawn_scheduler dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .Shift      (Shift),
    .restart    (restart),
    .isAlive    (isAlive),
    .table_addr (table_addr),
    .table_data (table_data),
    .start      (start),
    .kill       (kill),
    .spawnX     (spawnX),
    .spawnY     (spawnY),
    .scroll_col (scroll_col),
    .table_done (table_done)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge Clk) table_data <= rom[table_addr];

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
  endtask

  task automatic shift_n(input int n);
    for (int i = 0; i < n; i++) begin
      Shift = 1'b1;
      tick();
    end
    Shift = 1'b0;
  endtask

  task automatic set_alive(input logic [3:0] a);
    isAlive = a;
    tick();
    tick();
  endtask

  // One frame edge; observe start pulses for 10 cycles.
  task automatic do_frame(output logic [3:0] st, output logic [9:0] sx,
                          output logic [9:0] sy, output int lat,
                          output int npulse, output logic [5:0] faddr,
                          output logic [9:0] after);
    st = '0; sx = '0; sy = '0; lat = -1;
    npulse = 0; faddr = '0; after = '1;
    frame_clk = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) faddr = table_addr;
      if (lat > 0 && c == lat + 1) after = spawnX | spawnY;
      if (start != '0) begin
        npulse++;
        if (lat < 0) begin
          lat = c; st = start; sx = spawnX; sy = spawnY;
        end
      end
      if (c == 6) frame_clk = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] col;
    logic [9:0] y;
    int         shifts;
    logic [3:0] alive;
    logic [3:0] exp_st;
    logic       exp_done;
  } vec_t;

  vec_t vt[10];

  logic [3:0] f_st;
  logic [9:0] f_sx, f_sy, f_after;
  int         f_lat, f_np;
  logic [5:0] f_addr;

  // Reference model state
  int         m_scroll, m_ptr, m_slot;
  logic [3:0] m_pend, m_free, m_exp, m_alive;
  logic       m_done;
  logic [9:0] m_y;
  int         cnum;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {8'hFF, 10'd0};

    vt[0] = '{8'd3,   10'd400, 0, 4'b0000, 4'b0001, 1'b0};
    vt[1] = '{8'd20,  10'd300, 0, 4'b0000, 4'b0000, 1'b0};
    vt[2] = '{8'd20,  10'd300, 8, 4'b0000, 4'b0001, 1'b0};
    vt[3] = '{8'd21,  10'd301, 8, 4'b0000, 4'b0000, 1'b0};
    vt[4] = '{8'd12,  10'd120, 0, 4'b0000, 4'b0001, 1'b0};
    vt[5] = '{8'd5,   10'd55,  0, 4'b1111, 4'b0000, 1'b0};
    vt[6] = '{8'd5,   10'd56,  0, 4'b1011, 4'b0100, 1'b0};
    vt[7] = '{8'd5,   10'd57,  0, 4'b0001, 4'b0010, 1'b0};
    vt[8] = '{8'd0,   10'd1,   0, 4'b0111, 4'b1000, 1'b0};
    vt[9] = '{8'hFF,  10'd9,   0, 4'b0000, 4'b0000, 1'b1};

    // Reset state
    #2;
    chk("rst_start", 32'(start), 0);
    chk("rst_kill", 32'(kill), 0);
    chk("rst_spawn", 32'({spawnX, spawnY}), 0);
    chk("rst_addr", 32'(table_addr), 0);
    chk("rst_scroll", 32'(scroll_col), 0);
    chk("rst_done", 32'(table_done), 0);
    tick();
    Reset_n = 1'b1;
    tick();

    // Vector table
    foreach (vt[i]) begin
      do_restart();
      rom[0] = {vt[i].col, vt[i].y};
      rom[1] = {8'hFF, 10'd0};
      shift_n(vt[i].shifts);
      set_alive(vt[i].alive);
      do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
      chk($sformatf("v%0d_start", i), 32'(f_st), 32'(vt[i].exp_st));
      chk($sformatf("v%0d_done", i), 32'(table_done), 32'(vt[i].exp_done));
      if (vt[i].exp_st != '0) begin
        chk($sformatf("v%0d_lat", i), 32'(f_lat), 5);
        chk($sformatf("v%0d_npulse", i), 32'(f_np), 1);
        chk($sformatf("v%0d_x", i), 32'(f_sx), 500);
        chk($sformatf("v%0d_y", i), 32'(f_sy), 32'(vt[i].y));
        chk($sformatf("v%0d_after", i), 32'(f_after), 0);
      end
      if (!vt[i].exp_done) begin
        do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
        chk($sformatf("v%0d_ptr", i), 32'(f_addr),
            (vt[i].exp_st != '0) ? 1 : 0);
      end
    end

    // Restart during WAIT
    do_restart();
    rom[0] = {8'd3, 10'd111};
    rom[1] = {8'd4, 10'd222};
    rom[2] = {8'hFF, 10'd0};
    set_alive(4'b0000);
    shift_n(5);
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("rs_pre_start", 32'(f_st), 32'b0001);
    frame_clk = 1'b1;
    f_np = 0;
    repeat (3) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    if (start != '0) f_np++;
    chk("rs_kill", 32'(kill), 32'b1111);
    chk("rs_scroll", 32'(scroll_col), 0);
    tick();
    if (start != '0) f_np++;
    chk("rs_kill_off", 32'(kill), 0);
    frame_clk = 1'b0;
    repeat (8) begin
      tick();
      if (start != '0) f_np++;
    end
    chk("rs_nostart", 32'(f_np), 0);
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("rs_ptr0", 32'(f_addr), 0);
    chk("rs_slot0", 32'(f_st), 32'b0001);
    chk("rs_y", 32'(f_sy), 111);

    // Pending keeps a started slot busy until it reports alive
    do_restart();
    rom[0] = {8'd2, 10'd100};
    rom[1] = {8'd3, 10'd200};
    rom[2] = {8'd4, 10'd300};
    rom[3] = {8'hFF, 10'd0};
    set_alive(4'b0000);
    shift_n(3);
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("pd_f1", 32'(f_st), 32'b0001);
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("pd_f2", 32'(f_st), 32'b0010);
    chk("pd_f2_y", 32'(f_sy), 200);
    set_alive(4'b0001);
    set_alive(4'b0000);
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("pd_f3", 32'(f_st), 32'b0001);
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("pd_end_start", 32'(f_st), 0);
    chk("pd_end_done", 32'(table_done), 1);
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("pd_done_quiet", 32'(f_np), 0);
    chk("pd_done_hold", 32'(table_done), 1);

    // Asynchronous reset in DONE, frame_clk held high across release
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_done", 32'(table_done), 0);
    chk("ar_scroll", 32'(scroll_col), 0);
    chk("ar_outs", 32'({start, kill, spawnX, spawnY, table_addr}), 0);
    frame_clk = 1'b1;
    tick();
    Reset_n = 1'b1;
    f_np = 0;
    repeat (10) begin
      tick();
      if (start != '0) f_np++;
    end
    chk("ar_noedge", 32'(f_np), 0);
    frame_clk = 1'b0;
    tick();
    do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
    chk("ar_resume", 32'(f_st), 32'b0001);

    // Scroll saturation
    do_restart();
    shift_n(260);
    chk("sat_scroll", 32'(scroll_col), 32'hFE);

    // Randomized frames against the reference model
    do_restart();
    set_alive(4'b0000);
    cnum = 0;
    for (int i = 0; i < 64; i++) begin
      cnum = cnum + int'($urandom_range(0, 1));
      rom[i] = {8'(cnum), 10'($urandom_range(0, 1023))};
    end
    m_scroll = 0; m_ptr = 0; m_pend = '0; m_done = 1'b0;
    for (int f = 0; f < 150; f++) begin
      int k;
      k = int'($urandom_range(0, 2));
      shift_n(k);
      m_scroll = (m_scroll + k > 254) ? 254 : m_scroll + k;
      m_alive = 4'($urandom);
      set_alive(m_alive);
      m_pend = m_pend & ~m_alive;

      m_exp = '0; m_y = '0;
      if (!m_done) begin
        if (rom[m_ptr][17:10] == 8'hFF) begin
          m_done = 1'b1;
        end else if (int'(rom[m_ptr][17:10]) <= m_scroll + 12) begin
          m_free = ~m_alive & ~m_pend;
          m_slot = -1;
          for (int b = 0; b < 4; b++)
            if (m_free[b] && m_slot < 0) m_slot = b;
          if (m_slot >= 0) begin
            m_exp = 4'b0001 << m_slot;
            m_y = rom[m_ptr][9:0];
            m_pend = m_pend | m_exp;
            if (m_ptr == 63) m_done = 1'b1;
            m_ptr = (m_ptr + 1) % 64;
          end
        end
      end

      do_frame(f_st, f_sx, f_sy, f_lat, f_np, f_addr, f_after);
      chk($sformatf("rnd%0d_start", f), 32'(f_st), 32'(m_exp));
      if (m_exp != '0)
        chk($sformatf("rnd%0d_y", f), 32'(f_sy), 32'(m_y));
      chk($sformatf("rnd%0d_done", f), 32'(table_done), 32'(m_done));
      chk($sformatf("rnd%0d_scroll", f), 32'(scroll_col), 32'(m_scroll));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
